codificador_prioridad_16a4: RTL and testbench

Registered 16-to-4 priority encoder with request latching and a valid/acknowledge handshake. It is the inverse of the team's 4-to-16 decoder tree. It collects up to 16 request lines into sticky pending bits and presents the index of the winning request on a 4-bit code. The code is held stable until the consumer acknowledges it. It sits in front of a 4-to-16 decoder, or of any consumer that services one request index at a time.

---
 rtl/codificador_prioridad_16a4.sv | 86 ++++++++
 tb/tb_codificador_prioridad_16a4.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/codificador_prioridad_16a4.sv
// Registered 16-to-4 priority encoder: sticky pending requests, one offered
// index at a time, held on salida until the consumer acknowledges it.
module codificador_prioridad_16a4 #(
  parameter bit ALTA_PRIMERO = 1'b1
) (
  input  logic        reloj,
  input  logic        reset_n,
  input  logic [15:0] entrada,
  input  logic        enable,
  input  logic        ack,
  output logic [3:0]  salida,
  output logic        valido,
  output logic [15:0] pendientes
);

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;

  typedef enum logic {ESPERA, OFERTA} estado_t;

  estado_t        estado, estado_sig;
  logic [N-1:0]   pend, pend_sig;
  logic [N-1:0]   clr_c;
  logic [W-1:0]   ganador_c;
  logic           carga_c;
  logic           acepta_c;

  // Winning index of the registered pending vector
  always_comb begin
    ganador_c = '0;
    if (ALTA_PRIMERO) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i]) ganador_c = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[i]) ganador_c = W'(i);
      end
    end
  end

  // Next state and handshake strobes
  always_comb begin
    estado_sig = estado;
    carga_c    = 1'b0;
    acepta_c   = 1'b0;
    case (estado)
      ESPERA: begin
        if (enable && (pend != '0)) begin
          carga_c    = 1'b1;
          estado_sig = OFERTA;
        end
      end
      OFERTA: begin
        if (ack) begin
          acepta_c   = 1'b1;
          estado_sig = ESPERA;
        end
      end
      default: estado_sig = ESPERA;
    endcase
  end

  // Accepted index is cleared; a same-cycle request re-sets it
  always_comb begin
    clr_c    = acepta_c ? (N'(1) << salida) : '0;
    pend_sig = (pend & ~clr_c) | (enable ? entrada : '0);
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      estado <= ESPERA;
      pend   <= '0;
      salida <= '0;
      valido <= 1'b0;
    end else begin
      estado <= estado_sig;
      pend   <= pend_sig;
      valido <= (estado_sig == OFERTA);
      if (carga_c) salida <= ganador_c;
    end
  end

  assign pendientes = pend;

endmodule

// File: tb/tb_codificador_prioridad_16a4.sv
// Bench for codificador_prioridad_16a4: both priority orders driven in
// parallel and compared every cycle against a transaction-level model.
module tb_codificador_prioridad_16a4;

  logic        reloj = 1'b0;
  logic        reset_n;
  logic [15:0] entrada;
  logic        enable;
  logic        ack;
  logic [3:0]  salida_a, salida_b;
  logic        valido_a, valido_b;
  logic [15:0] pend_a, pend_b;

  int checks = 0;
  int fallos = 0;

  // Model state; index 1 = highest-first, index 0 = lowest-first
  logic [15:0] m_pend [2];
  logic [3:0]  m_sal  [2];
  logic        m_val  [2];

  codificador_prioridad_16a4 #(.ALTA_PRIMERO(1'b1)) dut_alta (
    .reloj(reloj), .reset_n(reset_n), .entrada(entrada), .enable(enable), .ack(ack),
    .salida(salida_a), .valido(valido_a), .pendientes(pend_a)
  );

  codificador_prioridad_16a4 #(.ALTA_PRIMERO(1'b0)) dut_baja (
    .reloj(reloj), .reset_n(reset_n), .entrada(entrada), .enable(enable), .ack(ack),
    .salida(salida_b), .valido(valido_b), .pendientes(pend_b)
  );

  always #5 reloj = ~reloj;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      fallos++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, esp, $time);
    end
  endtask

  function automatic logic [3:0] ganador(input logic [15:0] p, input bit alta);
    int v;
    int w;
    int lsb;
    v = int'(p);
    w = 0;
    if (alta) begin
      w = 15;
      while (((v >> w) & 1) == 0) w--;
    end else begin
      lsb = v & (-v);
      while (lsb > 1) begin
        lsb = lsb >> 1;
        w++;
      end
    end
    return 4'(w);
  endfunction

  function automatic void modelo_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = '0;
      m_sal[k]  = '0;
      m_val[k]  = 1'b0;
    end
  endfunction

  function automatic void modelo_paso(input int k);
    logic [15:0] clr;
    logic [15:0] nuevo;
    clr   = (m_val[k] && ack) ? 16'(1 << m_sal[k]) : 16'h0;
    nuevo = (m_pend[k] & ~clr) | (enable ? entrada : 16'h0);
    if (!m_val[k]) begin
      if (enable && m_pend[k] != 16'h0) begin
        m_sal[k] = ganador(m_pend[k], k == 1);
        m_val[k] = 1'b1;
      end
    end else if (ack) begin
      m_val[k] = 1'b0;
    end
    m_pend[k] = nuevo;
  endfunction

  task automatic verificar();
    comprobar("alta.valido", 32'(valido_a), 32'(m_val[1]));
    comprobar("alta.salida", 32'(salida_a), 32'(m_sal[1]));
    comprobar("alta.pend",   32'(pend_a),   32'(m_pend[1]));
    comprobar("baja.valido", 32'(valido_b), 32'(m_val[0]));
    comprobar("baja.salida", 32'(salida_b), 32'(m_sal[0]));
    comprobar("baja.pend",   32'(pend_b),   32'(m_pend[0]));
  endtask

  task automatic ciclo(input logic [15:0] e, input logic en, input logic a);
    entrada = e;
    enable  = en;
    ack     = a;
    @(posedge reloj);
    modelo_paso(0);
    modelo_paso(1);
    #1;
    verificar();
  endtask

  initial begin
    reset_n = 1'b0;
    entrada = '0;
    enable  = 1'b0;
    ack     = 1'b0;
    modelo_reset();
    #12;
    comprobar("reset.salida", 32'(salida_a), 32'h0);
    comprobar("reset.valido", 32'(valido_a), 32'h0);
    comprobar("reset.pend",   32'(pend_a),   32'h0);
    reset_n = 1'b1;
    @(posedge reloj);
    #1;

    // Single request: pending after one edge, offer after two, cleared by ack
    ciclo(16'h0020, 1'b1, 1'b0);
    comprobar("single.pend", 32'(pend_a), 32'h0020);
    comprobar("single.noval", 32'(valido_a), 32'h0);
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("single.valido", 32'(valido_a), 32'h1);
    comprobar("single.salida", 32'(salida_a), 32'h5);
    ciclo(16'h0000, 1'b1, 1'b1);
    comprobar("single.ackval", 32'(valido_a), 32'h0);
    comprobar("single.ackpend", 32'(pend_a), 32'h0);

    // Priority order in both configurations
    ciclo(16'h8001, 1'b1, 1'b0);
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("prio.alta1", 32'(salida_a), 32'hF);
    comprobar("prio.baja1", 32'(salida_b), 32'h0);
    ciclo(16'h0000, 1'b1, 1'b1);
    comprobar("prio.gap", 32'(valido_a), 32'h0);
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("prio.alta2", 32'(salida_a), 32'h0);
    comprobar("prio.baja2", 32'(salida_b), 32'hF);
    ciclo(16'h0000, 1'b1, 1'b1);

    // Offer held without ack; no preemption by a later request
    ciclo(16'h0008, 1'b1, 1'b0);
    ciclo(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ciclo((i == 0) ? 16'h1000 : 16'h0000, 1'b1, 1'b0);
      comprobar("hold.salida", 32'(salida_a), 32'h3);
      comprobar("hold.valido", 32'(valido_a), 32'h1);
    end
    comprobar("hold.pend", 32'(pend_a), 32'h1008);
    ciclo(16'h0000, 1'b1, 1'b1);
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("hold.next", 32'(salida_a), 32'hC);
    ciclo(16'h0000, 1'b1, 1'b1);

    // Set beats clear
    ciclo(16'h0080, 1'b1, 1'b0);
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("sbc.salida", 32'(salida_a), 32'h7);
    ciclo(16'h0080, 1'b1, 1'b1);
    comprobar("sbc.pend", 32'(pend_a), 32'h0080);
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("sbc.reoffer", 32'(valido_a), 32'h1);
    comprobar("sbc.resalida", 32'(salida_a), 32'h7);
    ciclo(16'h0000, 1'b1, 1'b1);

    // Enable gating
    ciclo(16'hFFFF, 1'b0, 1'b0);
    comprobar("gate.pend", 32'(pend_a), 32'h0);
    ciclo(16'h0000, 1'b0, 1'b0);
    comprobar("gate.noval", 32'(valido_a), 32'h0);
    ciclo(16'h0002, 1'b1, 1'b0);
    ciclo(16'h0004, 1'b1, 1'b0);
    comprobar("gate.offer", 32'(salida_a), 32'h1);
    ciclo(16'h0000, 1'b0, 1'b1);
    comprobar("gate.ack", 32'(valido_a), 32'h0);
    comprobar("gate.ackpend", 32'(pend_a), 32'h0004);
    for (int i = 0; i < 3; i++) begin
      ciclo(16'h0000, 1'b0, 1'b0);
      comprobar("gate.frozen", 32'(valido_a), 32'h0);
    end
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("gate.resume", 32'(salida_a), 32'h2);
    ciclo(16'h0000, 1'b1, 1'b1);

    // Asynchronous reset during a live offer
    ciclo(16'h00F0, 1'b1, 1'b0);
    ciclo(16'h0000, 1'b1, 1'b0);
    comprobar("arst.pre", 32'(salida_a), 32'h7);
    comprobar("arst.prepend", 32'(pend_a), 32'h00F0);
    #2 reset_n = 1'b0;
    #1;
    comprobar("arst.salida", 32'(salida_a), 32'h0);
    comprobar("arst.valido", 32'(valido_a), 32'h0);
    comprobar("arst.pend",   32'(pend_a),   32'h0);
    comprobar("arst.bsalida", 32'(salida_b), 32'h0);
    modelo_reset();
    @(negedge reloj);
    reset_n = 1'b1;
    @(posedge reloj);
    #1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] e;
      e = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(3) == 0) e = '0;
      ciclo(e, $urandom_range(9) < 8, $urandom_range(1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fallos);
    $finish;
  end

endmodule
